// File: rtl/l2_request_adapter.sv
// l2_request_adapter
//   Turns the dcache's level-held L2 word requests into single-beat
//   valid/ready transactions on the memory bus and returns one
//   l2_req_fulfilled pulse per completed word. Serves line flushes (STORE)
//   and line fills (LOAD).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   l2_req_*            level-held request from the dcache (valid/type/address/wdata)
//   l2_req_fulfilled    one-cycle completion pulse
//   l2_rdata            load data, valid while l2_req_fulfilled is high
//   mem_req_*           single-beat bus request (valid/ready/write/address/wdata)
//   mem_resp_*          bus response / write acknowledge
//   bus_error           sticky flag: response timeout or illegal request type
//
// All outputs are registered; nothing combinational runs from an input to
// an output.

package l2_request_adapter_pkg;
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01
  } memory_operation_e;
endpackage

module l2_request_adapter
  import l2_request_adapter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              l2_req_valid,
  input  memory_operation_e l2_req_type,
  input  logic [ADDR_W-1:0] l2_req_address,
  input  logic [XLEN-1:0]   l2_req_wdata,
  output logic              l2_req_fulfilled,
  output logic [XLEN-1:0]   l2_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_address,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  output logic              bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_RECOVER, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_valid_q, req_valid_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              fulfilled_q, fulfilled_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_valid_d = 1'b0;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fulfilled_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (l2_req_valid) begin
          if (l2_req_type == LOAD || l2_req_type == STORE) begin
            // Latch the request; the bus side only ever sees these copies,
            // so later changes on l2_req_* cannot disturb this transaction.
            state_d     = S_ISSUE;
            req_valid_d = 1'b1;
            write_d     = (l2_req_type == STORE);
            addr_d      = l2_req_address;
            wdata_d     = l2_req_wdata;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          req_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        // A response in the final permitted cycle still wins over the timeout.
        if (mem_resp_valid) begin
          state_d     = S_DONE;
          fulfilled_d = 1'b1;
          if (!write_q) rdata_d = mem_resp_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:    state_d = S_RECOVER;
      // One dead cycle absorbs the requester's address update and its
      // trailing valid, so the last word is never issued twice.
      S_RECOVER: state_d = S_IDLE;
      S_ERROR:   err_d   = 1'b1;
      default:   state_d = S_IDLE;
    endcase

    // ERROR presents nothing but bus_error.
    if (state_d == S_ERROR) begin
      req_valid_d = 1'b0;
      write_d     = 1'b0;
      addr_d      = '0;
      wdata_d     = '0;
      fulfilled_d = 1'b0;
      rdata_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fulfilled_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fulfilled_q <= fulfilled_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_valid    = req_valid_q;
  assign mem_req_write    = write_q;
  assign mem_req_address  = addr_q;
  assign mem_req_wdata    = wdata_q;
  assign l2_req_fulfilled = fulfilled_q;
  assign l2_rdata         = rdata_q;
  assign bus_error        = err_q;

endmodule
